// File: rtl/smc_pkg.sv
// Shared types and constants for the smc_topk ranked-sum block.
package smc_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DRAIN,
        ST_SUM,
        ST_OUT
    } state_t;

    localparam int MODE_ID_BIT    = 0;
    localparam int MODE_LARGE_BIT = 1;
    localparam int WEIGHT_BASE    = 3;
endpackage

// File: rtl/smc_calc.sv
// Combinational region select and per-transistor value: floor(product/3).
module smc_calc #(
    parameter int IN_W  = 3,
    parameter int VAL_W = 10
) (
    input  logic             id_mode,
    input  logic [IN_W-1:0]  w,
    input  logic [IN_W-1:0]  v_gs,
    input  logic [IN_W-1:0]  v_ds,
    output logic [VAL_W-1:0] value
);
    localparam int    PW    = 3 * IN_W + 2;
    localparam longint M    = (longint'(1) << IN_W) - 1;

    // Worst-case product is bounded by 2*M^3.
    if ((2 * M * M * M) / 3 >= (longint'(1) << VAL_W)) begin : g_width_chk
        $error("smc_calc: VAL_W too narrow for IN_W");
    end

    logic          triode;
    logic [PW-1:0] pw, pgs, pds, prod, quot;

    always_comb begin
        pw     = PW'(w);
        pgs    = PW'(v_gs);
        pds    = PW'(v_ds);
        triode = pgs > pds + PW'(1);
        prod   = '0;
        if (triode)
            prod = id_mode ? pds * pw * (PW'(2) * pgs - pds - PW'(2))
                           : PW'(2) * pw * pds;
        else if (v_gs != '0)
            prod = id_mode ? pw * (pgs - PW'(1)) * (pgs - PW'(1))
                           : PW'(2) * pw * (pgs - PW'(1));
        quot  = prod / PW'(3);
        value = VAL_W'(quot);
    end
endmodule

// File: rtl/smc_topk.sv
// Per-frame top-K rank buffer over transistor values, emitting a weighted sum.
module smc_topk
    import smc_pkg::*;
#(
    parameter int IN_W  = 3,
    parameter int K     = 3,
    parameter int MAX_N = 64,
    parameter int VAL_W = 10,
    parameter int OUT_W = 12,
    localparam int CNT_W = $clog2(MAX_N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  W,
    input  logic [IN_W-1:0]  V_GS,
    input  logic [IN_W-1:0]  V_DS,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_n,
    output logic [CNT_W-1:0] out_cnt
);
    if (K < 1 || K > 8) begin : g_k_chk
        $error("smc_topk: K must be 1..8");
    end

    localparam int          SUM_W   = VAL_W + 8;
    localparam logic [63:0] OUT_MAX = (64'd1 << OUT_W) - 64'd1;

    state_t                      state;
    logic [1:0]                  mode_r, eff_mode;
    logic [CNT_W-1:0]            cnt, cnt_next;
    logic                        fire, frame_end;
    logic                        s1_vld;
    logic [VAL_W-1:0]            s1_val, calc_val;
    logic [K-1:0][VAL_W-1:0]     rank_q, rank_d;
    logic [K-1:0]                rvld_q, rvld_d;
    logic [SUM_W-1:0]            sum;

    assign in_ready  = (state == ST_IDLE) || (state == ST_COLLECT);
    assign fire      = in_valid && in_ready;
    // Mode is latched on the first beat, but that beat must already use it.
    assign eff_mode  = (state == ST_IDLE) ? mode : mode_r;
    assign cnt_next  = (state == ST_IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
    assign frame_end = in_last || (cnt_next == CNT_W'(MAX_N));

    smc_calc #(.IN_W(IN_W), .VAL_W(VAL_W)) u_calc (
        .id_mode (eff_mode[MODE_ID_BIT]),
        .w       (W),
        .v_gs    (V_GS),
        .v_ds    (V_DS),
        .value   (calc_val)
    );

    // Buffer is kept descending with valid entries packed at the front.
    always_comb begin
        int pos;
        int p;
        rank_d = rank_q;
        rvld_d = rvld_q;
        pos    = K;
        p      = K;
        if (mode_r[MODE_LARGE_BIT] || !rvld_q[K-1]) begin
            for (int i = K - 1; i >= 0; i--)
                if (!rvld_q[i] || s1_val > rank_q[i]) pos = i;
            for (int i = K - 1; i > 0; i--)
                if (i > pos) begin
                    rank_d[i] = rank_q[i-1];
                    rvld_d[i] = rvld_q[i-1];
                end
            for (int i = 0; i < K; i++)
                if (i == pos) begin
                    rank_d[i] = s1_val;
                    rvld_d[i] = 1'b1;
                end
        end else if (s1_val < rank_q[0]) begin
            // Full and keeping smallest: evict the head, slide up, place value.
            for (int j = K - 1; j > 0; j--)
                if (s1_val >= rank_q[j]) p = j;
            for (int i = 0; i < K - 1; i++)
                if (i < p - 1) rank_d[i] = rank_q[i+1];
            for (int i = 0; i < K; i++)
                if (i == p - 1) rank_d[i] = s1_val;
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < K; i++)
            if (rvld_q[i])
                sum = sum + SUM_W'(rank_q[i]) *
                      SUM_W'(mode_r[MODE_ID_BIT] ? WEIGHT_BASE + i : 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            mode_r    <= '0;
            cnt       <= '0;
            s1_vld    <= 1'b0;
            s1_val    <= '0;
            rank_q    <= '0;
            rvld_q    <= '0;
            out_valid <= 1'b0;
            out_n     <= '0;
            out_cnt   <= '0;
        end else begin
            s1_vld <= fire;
            if (fire) s1_val <= calc_val;
            if (s1_vld) begin
                rank_q <= rank_d;
                rvld_q <= rvld_d;
            end
            case (state)
                ST_IDLE: if (fire) begin
                    mode_r <= mode;
                    cnt    <= cnt_next;
                    state  <= frame_end ? ST_DRAIN : ST_COLLECT;
                end
                ST_COLLECT: if (fire) begin
                    cnt <= cnt_next;
                    if (frame_end) state <= ST_DRAIN;
                end
                ST_DRAIN: state <= ST_SUM;
                ST_SUM: begin
                    out_valid <= 1'b1;
                    out_n     <= (64'(sum) > OUT_MAX) ? '1 : OUT_W'(sum);
                    out_cnt   <= cnt;
                    state     <= ST_OUT;
                end
                ST_OUT: begin
                    out_valid <= 1'b0;
                    rank_q    <= '0;
                    rvld_q    <= '0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_smc_topk.sv
// Scoreboard bench for smc_topk: a default instance and a MAX_N=4/OUT_W=8 instance.
module tb_smc_topk;
    typedef struct {
        int  n;
        int  cnt;
        time t;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       iv[2], il[2];
    logic [1:0] md[2];
    logic [2:0] wv[2], gs[2], ds[2];
    logic       rdy0, rdy1, ov0, ov1;
    logic [11:0] on0;
    logic [6:0]  oc0;
    logic [7:0]  on1;
    logic [2:0]  oc1;

    exp_t q0[$], q1[$];
    int   tests = 0, errs = 0;
    int   fw[8], fg[8], fv[8];

    always #5 clk = ~clk;

    smc_topk dut0 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(rdy0), .in_last(il[0]),
        .mode(md[0]), .W(wv[0]), .V_GS(gs[0]), .V_DS(ds[0]),
        .out_valid(ov0), .out_n(on0), .out_cnt(oc0)
    );

    smc_topk #(.MAX_N(4), .OUT_W(8)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(rdy1), .in_last(il[1]),
        .mode(md[1]), .W(wv[1]), .V_GS(gs[1]), .V_DS(ds[1]),
        .out_valid(ov1), .out_n(on1), .out_cnt(oc1)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_pulse(input int d, input int n, input int c, input logic r);
        exp_t e;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            chk($sformatf("dut%0d unexpected out_valid (out_n)", d), n, -1);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("dut%0d out_n", d), n, e.n);
        chk($sformatf("dut%0d out_cnt", d), c, e.cnt);
        chk($sformatf("dut%0d latency", d), int'($time - e.t), 25);
        chk($sformatf("dut%0d in_ready during out", d), int'(r), 0);
    endtask

    always @(negedge clk) begin
        if (ov0) check_pulse(0, int'(on0), int'(oc0), rdy0);
        if (ov1) check_pulse(1, int'(on1), int'(oc1), rdy1);
    end

    task automatic send(input int d, input logic [1:0] m, input int w_, input int g_,
                        input int v_, input logic last, output time t);
        int n = 0;
        iv[d] = 1'b1;
        il[d] = last;
        md[d] = m;
        wv[d] = 3'(w_);
        gs[d] = 3'(g_);
        ds[d] = 3'(v_);
        t     = 0;
        @(negedge clk);
        while (!(d == 0 ? rdy0 : rdy1)) begin
            n++;
            if (n > 20) begin
                chk($sformatf("dut%0d in_ready timeout", d), 0, 1);
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        t = $time;
        #1;
    endtask

    // Sends fw/fg/fv[0..nb-1]; in_valid stays high afterwards.
    task automatic frame(input int d, input logic [1:0] m, input int nb,
                         input int exp_n, input int exp_cnt);
        time  t;
        exp_t e;
        for (int i = 0; i < nb; i++)
            send(d, m, fw[i], fg[i], fv[i], i == nb - 1, t);
        e.n = exp_n; e.cnt = exp_cnt; e.t = t;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic idle(input int d);
        iv[d] = 1'b0;
        il[d] = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q0.size() != 0 || q1.size() != 0) begin
            n++;
            if (n > 50) begin
                chk("scoreboard drain timeout (pending)", q0.size() + q1.size(), 0);
                q0.delete();
                q1.delete();
                return;
            end
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        time  t;
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; il[d] = 1'b0; md[d] = 2'b00;
            wv[d] = '0; gs[d] = '0; ds[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset out_valid", int'(ov0), 0);
        chk("reset out_n", int'(on0), 0);
        chk("reset out_cnt", int'(oc0), 0);
        chk("reset in_ready", int'(rdy0), 1);
        chk("reset dut1 in_ready", int'(rdy1), 1);
        @(posedge clk); #1;

        // Same sat frame in all four modes, in_valid held high between frames.
        fw = '{3, 6, 3, 6, 3, 7, 0, 0};
        fg = '{4, 4, 2, 2, 1, 7, 0, 0};
        fv = '{7, 7, 7, 7, 7, 7, 0, 0};
        frame(0, 2'b11, 6, 369, 6);
        frame(0, 2'b01, 6, 10, 6);
        frame(0, 2'b10, 6, 46, 6);
        frame(0, 2'b00, 6, 6, 6);
        // Single triode beat: ID 14/3=4, weight 3; gm 4/3=1, weight 1.
        fw = '{2, 0, 0, 0, 0, 0, 0, 0};
        fg = '{5, 0, 0, 0, 0, 0, 0, 0};
        fv = '{1, 0, 0, 0, 0, 0, 0, 0};
        frame(0, 2'b01, 1, 12, 1);
        frame(0, 2'b00, 1, 1, 1);
        // V_GS = V_DS+2 is triode: 2*(8-2-2)=8 -> 2, weight 3.
        fw = '{1, 0, 0, 0, 0, 0, 0, 0};
        fg = '{4, 0, 0, 0, 0, 0, 0, 0};
        fv = '{2, 0, 0, 0, 0, 0, 0, 0};
        frame(0, 2'b01, 1, 6, 1);
        // V_GS=0 in saturation gives 0, not a wrapped (V_GS-1)^2.
        fw = '{7, 3, 0, 0, 0, 0, 0, 0};
        fg = '{0, 4, 0, 0, 0, 0, 0, 0};
        fv = '{7, 7, 0, 0, 0, 0, 0, 0};
        frame(0, 2'b11, 2, 27, 2);
        // Equal values: 9*3 + 9*4.
        fw = '{3, 3, 0, 0, 0, 0, 0, 0};
        fg = '{4, 4, 0, 0, 0, 0, 0, 0};
        fv = '{7, 7, 0, 0, 0, 0, 0, 0};
        frame(0, 2'b11, 2, 63, 2);
        idle(0);
        wait_drain();

        // Reset after three beats discards the frame.
        for (int i = 0; i < 3; i++) send(0, 2'b11, 6, 4, 7, 1'b0, t);
        idle(0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midreset out_n", int'(on0), 0);
        chk("midreset out_valid", int'(ov0), 0);
        chk("midreset out_cnt", int'(oc0), 0);
        chk("midreset in_ready", int'(rdy0), 1);
        repeat (6) @(posedge clk);
        #1;
        fw = '{2, 0, 0, 0, 0, 0, 0, 0};
        fg = '{5, 0, 0, 0, 0, 0, 0, 0};
        fv = '{1, 0, 0, 0, 0, 0, 0, 0};
        frame(0, 2'b01, 1, 12, 1);
        idle(0);
        wait_drain();

        // MAX_N=4: forced close after beat 4 (values 9,18,1,2 -> 18*3+9*4+2*5).
        for (int i = 0; i < 4; i++) begin
            send(1, 2'b11, (i % 2 == 0) ? 3 : 6, (i < 2) ? 4 : 2, 7, 1'b0, t);
        end
        e.n = 100; e.cnt = 4; e.t = t;
        q1.push_back(e);
        // Beat 5 opens the next frame; beat 6 mode is ignored (ID 18 not gm 12).
        // 84*3 + 18*4 = 324 saturates to 255.
        send(1, 2'b11, 7, 7, 7, 1'b0, t);
        send(1, 2'b00, 6, 4, 7, 1'b1, t);
        e.n = 255; e.cnt = 2; e.t = t;
        q1.push_back(e);
        idle(1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
